// File: rtl/timing_ring.sv
// Ring counter of POSITIONS one-hot stages with start/stop run control,
// per-position fixed-width pulses and a wrap marker.
module timing_ring #(
  parameter int POSITIONS = 8,
  parameter int PULSE_LEN = 2
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_advance,
  input  logic                 i_advance_gate,
  input  logic                 i_dc_reset,
  input  logic                 i_start,
  input  logic                 i_stop,
  output logic [POSITIONS-1:0] o_pos,
  output logic [POSITIONS-1:0] o_npos,
  output logic [POSITIONS-1:0] o_pulse,
  output logic                 o_running,
  output logic                 o_cycle_end
);

  // state    | meaning
  // IDLE     | ring parked, advances ignored
  // RUN      | advances step the ring
  // STOPPING | running, stop requested; halts on next wrap to position 0
  typedef enum logic [1:0] {IDLE, RUN, STOPPING} run_state_t;

  localparam logic [POSITIONS-1:0] HOME = POSITIONS'(1);

  run_state_t           state, state_next;
  logic                 last_advance, last_start, last_stop;
  logic                 advance_ev, start_ev, stop_ev;
  logic                 step, wrap;
  logic [POSITIONS-1:0] pos;
  logic [3:0]           pulse_cnt;
  logic                 cycle_end;

  assign advance_ev = i_advance & ~last_advance;
  assign start_ev   = i_start & ~last_start;
  assign stop_ev    = i_stop & ~last_stop;
  assign step       = advance_ev & i_advance_gate & o_running;
  assign wrap       = step & pos[POSITIONS-1];

  // Edge detectors keep sampling through dc reset so held inputs never fire on release.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      last_advance <= 1'b0;
      last_start   <= 1'b0;
      last_stop    <= 1'b0;
    end else begin
      last_advance <= i_advance;
      last_start   <= i_start;
      last_stop    <= i_stop;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) state <= IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (!i_dc_reset) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:     if (start_ev) state_next = RUN;
        RUN: begin
          if (wrap && stop_ev) state_next = IDLE;
          else if (stop_ev)    state_next = STOPPING;
        end
        STOPPING: if (wrap) state_next = IDLE;
        default:  state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    o_running = 1'b0;
    if (state != IDLE) o_running = 1'b1;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      pos       <= HOME;
      pulse_cnt <= 4'd0;
      cycle_end <= 1'b0;
    end else if (!i_dc_reset) begin
      pos       <= HOME;
      pulse_cnt <= 4'd0;
      cycle_end <= 1'b0;
    end else begin
      cycle_end <= wrap;
      if (step) begin
        pos       <= {pos[POSITIONS-2:0], pos[POSITIONS-1]};
        pulse_cnt <= 4'(PULSE_LEN);
      end else if (pulse_cnt != 4'd0) begin
        pulse_cnt <= pulse_cnt - 4'd1;
      end
    end
  end

  // The pulse rides on the one-hot position, so at most one bit is ever high.
  assign o_pos       = pos;
  assign o_npos      = ~pos;
  assign o_pulse     = (pulse_cnt != 4'd0) ? pos : '0;
  assign o_cycle_end = cycle_end;

endmodule

// File: tb/tb_timing_ring.sv
// Self-checking bench for timing_ring: directed scenarios plus a randomized
// run, all compared against an integer-position behavioural model.
module tb_timing_ring;
  localparam int N  = 8;
  localparam int PL = 2;

  logic         i_clk = 1'b0;
  logic         i_reset = 1'b0;
  logic         i_advance = 1'b0;
  logic         i_advance_gate = 1'b0;
  logic         i_dc_reset = 1'b1;
  logic         i_start = 1'b0;
  logic         i_stop = 1'b0;
  logic [N-1:0] o_pos, o_npos, o_pulse;
  logic         o_running, o_cycle_end;

  int errors = 0;
  int checks = 0;

  // model: position as an integer index, pulse as clocks remaining
  int m_pos, m_plen;
  bit m_run, m_pend, m_cend;
  bit m_la, m_ls, m_lp;

  timing_ring #(.POSITIONS(N), .PULSE_LEN(PL)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_advance(i_advance),
    .i_advance_gate(i_advance_gate), .i_dc_reset(i_dc_reset),
    .i_start(i_start), .i_stop(i_stop), .o_pos(o_pos), .o_npos(o_npos),
    .o_pulse(o_pulse), .o_running(o_running), .o_cycle_end(o_cycle_end)
  );

  always #5 i_clk = ~i_clk;

  task automatic model_reset();
    m_pos = 0; m_plen = 0; m_run = 0; m_pend = 0; m_cend = 0;
    m_la = 0; m_ls = 0; m_lp = 0;
  endtask

  task automatic model_clk();
    bit ae, se, pe, stepped, wrapped;
    if (i_reset) begin
      model_reset();
      return;
    end
    ae = i_advance && !m_la;
    se = i_start && !m_ls;
    pe = i_stop && !m_lp;
    m_la = i_advance; m_ls = i_start; m_lp = i_stop;
    if (!i_dc_reset) begin
      m_pos = 0; m_plen = 0; m_run = 0; m_pend = 0; m_cend = 0;
      return;
    end
    stepped = ae && i_advance_gate && m_run;
    wrapped = stepped && (m_pos == N - 1);
    m_cend = wrapped;
    if (!m_run) begin
      if (se) begin m_run = 1; m_pend = 0; end
    end else if (wrapped && (m_pend || pe)) begin
      m_run = 0; m_pend = 0;
    end else if (pe) begin
      m_pend = 1;
    end
    if (stepped) begin
      m_pos = (m_pos + 1) % N;
      m_plen = PL;
    end else if (m_plen > 0) begin
      m_plen = m_plen - 1;
    end
  endtask

  function automatic logic [N-1:0] exp_pos();
    logic [N-1:0] e;
    e = '0;
    e[m_pos] = 1'b1;
    return e;
  endfunction

  function automatic logic [N-1:0] exp_pulse();
    return (m_plen > 0) ? exp_pos() : '0;
  endfunction

  task automatic tick();
    @(posedge i_clk);
    model_clk();
    #1;
  endtask

  task automatic advance_once();
    i_advance = 1'b1; tick();
    i_advance = 1'b0; tick();
  endtask

  task automatic test_reset();
    #2 i_reset = 1'b1;
    #1 model_reset();
    checks++; if (o_pos !== 8'h01) begin errors++; $display("FAIL reset_pos got %h exp %h", o_pos, 8'h01); end
    checks++; if (o_npos !== 8'hFE) begin errors++; $display("FAIL reset_npos got %h exp %h", o_npos, 8'hFE); end
    checks++; if (o_pulse !== 8'h00) begin errors++; $display("FAIL reset_pulse got %h exp %h", o_pulse, 8'h00); end
    checks++; if (o_running !== 1'b0 || o_cycle_end !== 1'b0) begin
      errors++; $display("FAIL reset_flags got run=%b cend=%b exp 0 0", o_running, o_cycle_end);
    end
    @(negedge i_clk);
    i_reset = 1'b0;
  endtask

  task automatic test_start_advance();
    i_start = 1'b1; tick();
    i_start = 1'b0;
    checks++; if (o_running !== 1'b1) begin errors++; $display("FAIL start_running got %b exp 1", o_running); end
    checks++; if (o_pulse !== 8'h00) begin errors++; $display("FAIL start_no_pulse got %h exp 00", o_pulse); end
    i_advance_gate = 1'b1;
    for (int k = 0; k < 3; k++) begin
      i_advance = 1'b1; tick();
      checks++; if (o_pulse !== exp_pulse()) begin errors++; $display("FAIL adv_pulse_first got %h exp %h", o_pulse, exp_pulse()); end
      i_advance = 1'b0; tick();
    end
    checks++; if (o_pos !== 8'h08) begin errors++; $display("FAIL adv3_pos got %h exp 08", o_pos); end
    checks++; if (o_npos !== 8'hF7) begin errors++; $display("FAIL adv3_npos got %h exp F7", o_npos); end
    checks++; if (o_pulse !== 8'h08) begin errors++; $display("FAIL adv3_pulse_2nd got %h exp 08", o_pulse); end
    tick();
    checks++; if (o_pulse !== 8'h00) begin errors++; $display("FAIL adv3_pulse_end got %h exp 00", o_pulse); end
  endtask

  task automatic test_wrap();
    int cend_seen = 0;
    logic [N-1:0] start_pos = o_pos;
    for (int k = 0; k < 8; k++) begin
      i_advance = 1'b1; tick();
      if (o_cycle_end === 1'b1) cend_seen++;
      checks++; if (o_cycle_end !== m_cend) begin errors++; $display("FAIL wrap_cend got %b exp %b", o_cycle_end, m_cend); end
      i_advance = 1'b0; tick();
      if (o_cycle_end === 1'b1) cend_seen++;
    end
    checks++; if (o_pos !== start_pos || o_pos !== exp_pos()) begin errors++; $display("FAIL wrap_pos got %h exp %h", o_pos, exp_pos()); end
    checks++; if (cend_seen != 1) begin errors++; $display("FAIL wrap_cend_count got %0d exp 1", cend_seen); end
    checks++; if (o_running !== 1'b1) begin errors++; $display("FAIL wrap_running got %b exp 1", o_running); end
  endtask

  task automatic test_stop();
    int cend_seen = 0;
    for (int k = 0; k < 2 * N && m_pos != 5; k++) advance_once();
    checks++; if (o_pos !== 8'h20) begin errors++; $display("FAIL stop_setup_pos got %h exp 20", o_pos); end
    i_stop = 1'b1; tick();
    i_stop = 1'b0;
    checks++; if (o_running !== 1'b1) begin errors++; $display("FAIL stop_pending_running got %b exp 1", o_running); end
    for (int k = 0; k < 3; k++) begin
      i_advance = 1'b1; tick();
      if (o_cycle_end === 1'b1) cend_seen++;
      i_advance = 1'b0; tick();
      if (o_cycle_end === 1'b1) cend_seen++;
    end
    checks++; if (o_pos !== 8'h01) begin errors++; $display("FAIL stop_pos got %h exp 01", o_pos); end
    checks++; if (o_running !== 1'b0) begin errors++; $display("FAIL stop_running got %b exp 0", o_running); end
    checks++; if (cend_seen != 1) begin errors++; $display("FAIL stop_cend_count got %0d exp 1", cend_seen); end
    advance_once(); advance_once();
    checks++; if (o_pos !== 8'h01 || o_pulse !== 8'h00) begin
      errors++; $display("FAIL stop_hold got pos=%h pulse=%h exp 01 00", o_pos, o_pulse);
    end
  endtask

  task automatic test_gate_idle();
    for (int k = 0; k < 3; k++) begin
      i_advance = 1'b1; tick();
      checks++; if (o_pos !== 8'h01 || o_pulse !== 8'h00) begin
        errors++; $display("FAIL idle_adv got pos=%h pulse=%h exp 01 00", o_pos, o_pulse);
      end
      i_advance = 1'b0; tick();
    end
    i_start = 1'b1; tick();
    i_start = 1'b0;
    i_advance_gate = 1'b0;
    for (int k = 0; k < 3; k++) begin
      i_advance = 1'b1; tick();
      checks++; if (o_pos !== 8'h01 || o_pulse !== 8'h00) begin
        errors++; $display("FAIL gated_adv got pos=%h pulse=%h exp 01 00", o_pos, o_pulse);
      end
      i_advance = 1'b0; tick();
    end
    i_advance = 1'b1; tick(); tick();
    i_advance_gate = 1'b1; tick(); tick();
    checks++; if (o_pos !== 8'h01 || o_running !== 1'b1) begin
      errors++; $display("FAIL held_adv_gate_rise got pos=%h run=%b exp 01 1", o_pos, o_running);
    end
    i_advance = 1'b0; tick();
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 12; k++) begin
      i_advance = ~i_advance; tick();
      checks++; if (o_pulse !== exp_pulse() || $countones(o_pulse) > 1) begin
        errors++; $display("FAIL b2b_pulse got %h exp %h", o_pulse, exp_pulse());
      end
    end
    checks++; if (o_pos !== exp_pos()) begin errors++; $display("FAIL b2b_pos got %h exp %h", o_pos, exp_pos()); end
  endtask

  task automatic test_dc_reset();
    for (int k = 0; k < 2 * N && m_pos != 5; k++) advance_once();
    i_advance = 1'b1; tick();
    i_advance = 1'b0;
    checks++; if (o_pulse !== 8'h40) begin errors++; $display("FAIL dc_setup_pulse got %h exp 40", o_pulse); end
    i_dc_reset = 1'b0; i_start = 1'b1; tick();
    checks++; if (o_pos !== 8'h01 || o_pulse !== 8'h00 || o_running !== 1'b0 || o_cycle_end !== 1'b0) begin
      errors++; $display("FAIL dc_force got pos=%h pulse=%h run=%b cend=%b exp 01 00 0 0", o_pos, o_pulse, o_running, o_cycle_end);
    end
    tick();
    i_dc_reset = 1'b1; tick();
    checks++; if (o_running !== 1'b0) begin errors++; $display("FAIL dc_held_start got %b exp 0", o_running); end
    i_start = 1'b0; tick();
  endtask

  task automatic test_async_reset();
    i_start = 1'b1; tick();
    i_start = 1'b0;
    i_advance = 1'b1; tick();
    i_advance = 1'b0;
    checks++; if (o_pulse !== 8'h02) begin errors++; $display("FAIL async_setup_pulse got %h exp 02", o_pulse); end
    #2 i_reset = 1'b1; i_start = 1'b1;
    #1 model_reset();
    checks++; if (o_pos !== 8'h01 || o_pulse !== 8'h00 || o_running !== 1'b0) begin
      errors++; $display("FAIL async_reset got pos=%h pulse=%h run=%b exp 01 00 0", o_pos, o_pulse, o_running);
    end
    @(negedge i_clk);
    i_reset = 1'b0;
    tick();
    checks++; if (o_running !== 1'b1 || o_pulse !== 8'h00) begin
      errors++; $display("FAIL release_start_event got run=%b pulse=%h exp 1 00", o_running, o_pulse);
    end
    i_start = 1'b0; tick();
  endtask

  task automatic test_random();
    for (int k = 0; k < 3000; k++) begin
      i_advance      = 1'($urandom_range(0, 1));
      i_advance_gate = ($urandom_range(0, 3) != 0);
      i_dc_reset     = ($urandom_range(0, 39) != 0);
      i_start        = ($urandom_range(0, 9) == 0);
      i_stop         = ($urandom_range(0, 11) == 0);
      tick();
      checks++; if (o_pos !== exp_pos() || o_npos !== ~exp_pos()) begin
        errors++; $display("FAIL rand_pos cyc %0d got %h/%h exp %h", k, o_pos, o_npos, exp_pos());
      end
      checks++; if (o_pulse !== exp_pulse()) begin
        errors++; $display("FAIL rand_pulse cyc %0d got %h exp %h", k, o_pulse, exp_pulse());
      end
      checks++; if (o_running !== m_run || o_cycle_end !== m_cend) begin
        errors++; $display("FAIL rand_flags cyc %0d got run=%b cend=%b exp %b %b", k, o_running, o_cycle_end, m_run, m_cend);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_start_advance();
    test_wrap();
    test_stop();
    test_gate_idle();
    test_back_to_back();
    test_dc_reset();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
